// File: rtl/textcon_pkg.sv
// -----------------------------------------------------------------------------
// textcon_pkg
// Shared definitions for the text console writer:
//   - control codes recognised in the byte stream (BS, LF, FF, CR)
//   - the console FSM state type
//   - default blank character used by clears and backspace
//   - cell address packing {row, col}
// Optional feature macro: TEXTCON_CLEAR_ROW_EN adds the CLR_ROW state.
// -----------------------------------------------------------------------------
package textcon_pkg;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1
`ifdef TEXTCON_CLEAR_ROW_EN
        ,
        CLR_ROW = 2'd2
`endif
    } state_t;

    // Row sits directly above the column field; caller truncates to ADDR_W.
    function automatic logic [31:0] pack_addr(input logic [15:0]  row,
                                              input logic [15:0]  col,
                                              input int unsigned  col_bits);
        pack_addr = (32'(row) << col_bits) | 32'(col);
    endfunction

endpackage

// File: rtl/textcon_clear_seq.sv
// -----------------------------------------------------------------------------
// textcon_clear_seq
// Walks cell coordinates row-major over rows [first..last], cols 0..COLS-1,
// one cell per clock. Used for both the full-screen clear and the single-row
// clear. Reset arms a full-screen walk starting at (0,0).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             load a new walk from (i_row_first, 0) to (i_row_last, COLS-1)
//   o_active            current coordinate is valid
//   o_row, o_col        current coordinate
//   o_done              current coordinate is the final one of the walk
// -----------------------------------------------------------------------------
module textcon_clear_seq #(
    parameter int unsigned COLS     = 32,
    parameter int unsigned ROWS     = 30,
    parameter int unsigned COL_BITS = 5,
    parameter int unsigned ROW_BITS = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ROW_BITS-1:0] i_row_first,
    input  logic [ROW_BITS-1:0] i_row_last,
    output logic                o_active,
    output logic [ROW_BITS-1:0] o_row,
    output logic [COL_BITS-1:0] o_col,
    output logic                o_done
);

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);

    logic                r_active;
    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] r_row_last;
    logic                w_done;

    assign w_done = r_active && (r_row == r_row_last) && (r_col == COL_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active   <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
            r_row_last <= ROW_MAX;
        end else if (i_start) begin
            r_active   <= 1'b1;
            r_row      <= i_row_first;
            r_col      <= '0;
            r_row_last <= i_row_last;
        end else if (r_active) begin
            if (w_done) begin
                r_active <= 1'b0;
            end else if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + ROW_ONE;
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end
    end

    assign o_active = r_active;
    assign o_row    = r_row;
    assign o_col    = r_col;
    assign o_done   = w_done;

endmodule

// File: rtl/text_console_writer.sv
// -----------------------------------------------------------------------------
// text_console_writer
// Character-stream front end for the 32x30 text-mode video memory. Accepts
// one byte per valid/ready handshake, tracks a cursor, interprets CR/LF/BS/FF
// and issues registered one-cycle writes to the video-memory write port.
// Ports:
//   clk_50mhz   system clock
//   rst         synchronous active-high reset (restarts the full clear)
//   in_data     character byte
//   in_valid    in_data valid
//   in_ready    byte accepted this cycle if in_valid (high only in IDLE)
//   vm_we       one-cycle write strobe
//   vm_addr     cell address {zeros, row, col}
//   vm_data     character written
//   cur_row     cursor row
//   cur_col     cursor column
//   busy        high while a clear runs (~in_ready)
// Optional feature macro: TEXTCON_CLEAR_ROW_EN - each row advance blanks the
// newly entered row before more bytes are accepted.
// -----------------------------------------------------------------------------
module text_console_writer
    import textcon_pkg::*;
#(
    parameter int unsigned COLS       = 32,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned COL_BITS   = 5,
    parameter int unsigned ROW_BITS   = 5,
    parameter int unsigned ADDR_W     = 12,
    parameter logic [7:0]  BLANK_CHAR = BLANK_CHAR_DEF
) (
    input  logic                clk_50mhz,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                vm_we,
    output logic [ADDR_W-1:0]   vm_addr,
    output logic [7:0]          vm_data,
    output logic [ROW_BITS-1:0] cur_row,
    output logic [COL_BITS-1:0] cur_col,
    output logic                busy
);

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_BITS-1:0] row,
                                                    input logic [COL_BITS-1:0] col);
        cell_addr = ADDR_W'(pack_addr(16'(row), 16'(col), COL_BITS));
    endfunction

    state_t              r_state;
    logic                r_vm_we;
    logic [ADDR_W-1:0]   r_vm_addr;
    logic [7:0]          r_vm_data;
    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;

    state_t              w_state_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [7:0]          w_data_nxt;
    logic [ROW_BITS-1:0] w_row_nxt;
    logic [COL_BITS-1:0] w_col_nxt;
    logic [ROW_BITS-1:0] w_row_adv;

    logic                w_seq_start;
    logic [ROW_BITS-1:0] w_seq_first;
    logic [ROW_BITS-1:0] w_seq_last;
    logic                w_seq_active;
    logic [ROW_BITS-1:0] w_seq_row;
    logic [COL_BITS-1:0] w_seq_col;
    logic                w_seq_done;

    textcon_clear_seq #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .COL_BITS (COL_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_clear_seq (
        .i_clk       (clk_50mhz),
        .i_rst       (rst),
        .i_start     (w_seq_start),
        .i_row_first (w_seq_first),
        .i_row_last  (w_seq_last),
        .o_active    (w_seq_active),
        .o_row       (w_seq_row),
        .o_col       (w_seq_col),
        .o_done      (w_seq_done)
    );

    // No scroll: advancing past the bottom row wraps to the top.
    assign w_row_adv = (r_row == ROW_MAX) ? '0 : r_row + ROW_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_vm_addr;
        w_data_nxt  = r_vm_data;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_seq_start = 1'b0;
        w_seq_first = '0;
        w_seq_last  = ROW_MAX;

        case (r_state)
            CLR_ALL: begin
                w_we_nxt   = w_seq_active;
                w_addr_nxt = cell_addr(w_seq_row, w_seq_col);
                w_data_nxt = BLANK_CHAR;
                if (w_seq_done) begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
`ifdef TEXTCON_CLEAR_ROW_EN
            CLR_ROW: begin
                w_we_nxt   = w_seq_active;
                w_addr_nxt = cell_addr(w_seq_row, w_seq_col);
                w_data_nxt = BLANK_CHAR;
                if (w_seq_done) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            IDLE: begin
                if (in_valid) begin
                    case (in_data)
                        CH_CR: begin
                            w_col_nxt = '0;
                        end
                        CH_LF: begin
                            w_col_nxt = '0;
                            w_row_nxt = w_row_adv;
`ifdef TEXTCON_CLEAR_ROW_EN
                            w_state_nxt = CLR_ROW;
                            w_seq_start = 1'b1;
                            w_seq_first = w_row_adv;
                            w_seq_last  = w_row_adv;
`endif
                        end
                        CH_BS: begin
                            if (r_col != '0) begin
                                w_col_nxt  = r_col - COL_ONE;
                                w_we_nxt   = 1'b1;
                                w_addr_nxt = cell_addr(r_row, r_col - COL_ONE);
                                w_data_nxt = BLANK_CHAR;
                            end
                        end
                        CH_FF: begin
                            w_row_nxt   = '0;
                            w_col_nxt   = '0;
                            w_state_nxt = CLR_ALL;
                            w_seq_start = 1'b1;
                        end
                        default: begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = cell_addr(r_row, r_col);
                            w_data_nxt = in_data;
                            if (r_col == COL_MAX) begin
                                w_col_nxt = '0;
                                w_row_nxt = w_row_adv;
`ifdef TEXTCON_CLEAR_ROW_EN
                                // The byte's own write is registered on this
                                // edge; the row clear follows from the next.
                                w_state_nxt = CLR_ROW;
                                w_seq_start = 1'b1;
                                w_seq_first = w_row_adv;
                                w_seq_last  = w_row_adv;
`endif
                            end else begin
                                w_col_nxt = r_col + COL_ONE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = CLR_ALL;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state   <= CLR_ALL;
            r_vm_we   <= 1'b0;
            r_vm_addr <= '0;
            r_vm_data <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vm_we   <= w_we_nxt;
            r_vm_addr <= w_addr_nxt;
            r_vm_data <= w_data_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = ~in_ready;
    assign vm_we    = r_vm_we;
    assign vm_addr  = r_vm_addr;
    assign vm_data  = r_vm_data;
    assign cur_row  = r_row;
    assign cur_col  = r_col;

endmodule

// File: tb/tb_text_console_writer.sv
// -----------------------------------------------------------------------------
// tb_text_console_writer
// Directed stimulus for text_console_writer. Each issued byte pushes its
// expected write(s) {addr, data, cycle} into a queue; a negedge monitor pops
// and compares every vm_we pulse. Cursor, ready and reset values are checked
// directly. Honours TEXTCON_CLEAR_ROW_EN when defined.
// -----------------------------------------------------------------------------
module tb_text_console_writer;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        vm_we;
    logic [11:0] vm_addr;
    logic [7:0]  vm_data;
    logic [4:0]  cur_row;
    logic [4:0]  cur_col;
    logic        busy;

    always #10 clk_50mhz = ~clk_50mhz;

    text_console_writer #(
        .COLS       (32),
        .ROWS       (30),
        .COL_BITS   (5),
        .ROW_BITS   (5),
        .ADDR_W     (12),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_data   (vm_data),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    // Monitor: every write strobe must match the head of the queue.
    always @(negedge clk_50mhz) begin
        if (vm_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr=%h data=%h cyc=%0d, required no write",
                         vm_addr, vm_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (vm_addr !== mon_e.addr || vm_data !== mon_e.data || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             vm_addr, vm_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_w(input logic [11:0] a, input logic [7:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_all_clear(input int c0);
        for (int i = 0; i < 960; i++) push_w(12'(i), 8'h20, c0 + i);
    endtask

    task automatic push_row_clear(input int row, input int c0);
        for (int i = 0; i < 32; i++) push_w(12'(row * 32 + i), 8'h20, c0 + i);
    endtask

    // Offer one byte, wait (bounded) for acceptance, queue expected writes,
    // then check the cursor right after the acceptance edge.
    task automatic send(input logic [7:0] b, input bit has_w, input logic [11:0] wa,
                        input logic [7:0] wd, input int clr_row,
                        input int er, input int ec, output int acc);
        int n = 0;
        @(negedge clk_50mhz);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance", b);
            in_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(posedge clk_50mhz);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        if (has_w) push_w(wa, wd, acc);
        if (b == 8'h0C) push_all_clear(acc + 1);
`ifdef TEXTCON_CLEAR_ROW_EN
        if (clr_row >= 0) push_row_clear(clr_row, acc + 1);
`else
        if (clr_row > 1000) push_row_clear(0, acc);
`endif
        chk($sformatf("cur_row_after_%h", b), 32'(cur_row), 32'(er));
        chk($sformatf("cur_col_after_%h", b), 32'(cur_col), 32'(ec));
    endtask

    // Hold a byte on the input while busy; it must not be taken early.
    // Withdrawn on the negedge where ready is first seen.
    task automatic wait_ready(input int exp_cyc, input string name);
        int n = 0;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        in_valid = 1'b0;
        chk(name, 32'(cyc), 32'(exp_cyc));
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int r;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk_50mhz);
        #1;
        chk("rst_vm_we",    32'(vm_we),    32'd0);
        chk("rst_vm_addr",  32'(vm_addr),  32'd0);
        chk("rst_vm_data",  32'(vm_data),  32'd0);
        chk("rst_cur_row",  32'(cur_row),  32'd0);
        chk("rst_cur_col",  32'(cur_col),  32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd1);

        // Power-up clear: 960 writes from the next edge, ready with the last.
        rst = 1'b0;
        r = cyc;
        push_all_clear(r + 1);
        wait_ready(r + 960, "init_ready_cycle");
        chk("init_cur_row", 32'(cur_row), 32'd0);
        chk("init_cur_col", 32'(cur_col), 32'd0);

        // "A","B" back-to-back.
        send(8'h41, 1, 12'h000, 8'h41, -1, 0, 1, acc);
        send(8'h42, 1, 12'h001, 8'h42, -1, 0, 2, acc2);
        chk("back_to_back", 32'(acc2), 32'(acc + 1));

        // Down to row 2, BS at column 0 does nothing.
        send(8'h0A, 0, 12'h000, 8'h00, 1, 1, 0, acc);
        send(8'h0A, 0, 12'h000, 8'h00, 2, 2, 0, acc);
        send(8'h08, 0, 12'h000, 8'h00, -1, 2, 0, acc);
        for (int i = 0; i < 4; i++)
            send(8'h30 + 8'(i), 1, 12'h040 + 12'(i), 8'h30 + 8'(i), -1, 2, i + 1, acc);
        // BS at (2,4) blanks (2,3).
        send(8'h08, 1, 12'h043, 8'h20, -1, 2, 3, acc);

        // Fill row 3 up to column 30, then the wrapping byte at (3,31).
        send(8'h0A, 0, 12'h000, 8'h00, 3, 3, 0, acc);
        for (int i = 0; i < 31; i++)
            send(8'h2E, 1, 12'h060 + 12'(i), 8'h2E, -1, 3, i + 1, acc);
        send(8'h58, 1, 12'h07F, 8'h58, 4, 4, 0, acc);
`ifdef TEXTCON_CLEAR_ROW_EN
        chk("wrap_ready_drops", 32'(in_ready), 32'd0);
`else
        chk("wrap_ready_stays", 32'(in_ready), 32'd1);
`endif

        // Walk to row 29, column 5; LF there wraps to the top.
        for (int i = 0; i < 25; i++)
            send(8'h0A, 0, 12'h000, 8'h00, 5 + i, 5 + i, 0, acc);
        for (int i = 0; i < 5; i++)
            send(8'h61 + 8'(i), 1, 12'h3A0 + 12'(i), 8'h61 + 8'(i), -1, 29, i + 1, acc);
        send(8'h0A, 0, 12'h000, 8'h00, 0, 0, 0, acc);
        for (int i = 0; i < 7; i++)
            send(8'h31 + 8'(i), 1, 12'(i), 8'h31 + 8'(i), -1, 0, i + 1, acc);
        send(8'h0D, 0, 12'h000, 8'h00, -1, 0, 0, acc);

        // FF mid-stream: full clear, byte held on the input is refused.
        send(8'h51, 1, 12'h000, 8'h51, -1, 0, 1, acc);
        send(8'h0C, 0, 12'h000, 8'h00, -1, 0, 0, acc);
        wait_ready(acc + 960, "ff_ready_cycle");

        // Reset pulse 100 cycles into a clear restarts it from address 0.
        send(8'h0C, 0, 12'h000, 8'h00, -1, 0, 0, acc);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        repeat (100) @(posedge clk_50mhz);
        #1;
        rst = 1'b1;
        // Write 99 is on the bus now; the rest of the old clear never appears.
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        @(posedge clk_50mhz);
        #1;
        rst = 1'b0;
        r = cyc;
        chk("midrst_vm_we",    32'(vm_we),    32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        push_all_clear(r + 1);
        wait_ready(r + 960, "midrst_ready_cycle");

        send(8'h5A, 1, 12'h000, 8'h5A, -1, 0, 1, acc);
        repeat (3) @(negedge clk_50mhz);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
